// File: rtl/rr_merge_arbiter.sv
// rr_merge_arbiter: round-robin merge node that forwards tokens from
// NUM_INPUTS upstream req/ack channels onto one downstream req/ack channel.
// Each forwarded token is tagged with the index of the channel it came from.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   req_l      request to upstream channel i (one-hot or zero)
//   ack_l      upstream ack pulses; din slice i is valid with ack_l[i]
//   din        upstream data, channel i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   req_r      downstream request level
//   ack_r      downstream ack, one-cycle pulse
//   dout       forwarded token
//   dout_id    source channel of dout
//
// Optional feature, macro ARB_TIMEOUT_EN: when defined, a channel that does
// not ack within TIMEOUT cycles of being requested is skipped. When undefined
// the arbiter waits on the selected channel indefinitely and TIMEOUT is unused
// apart from its range check.
module rr_merge_arbiter #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [NUM_INPUTS-1:0]            req_l,
    input  logic [NUM_INPUTS-1:0]            ack_l,
    input  logic [DATA_WIDTH*NUM_INPUTS-1:0] din,
    input  logic                             req_r,
    output logic                             ack_r,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic [ID_WIDTH-1:0]              dout_id
);

    localparam int unsigned PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    // Elaboration-time parameter sanity checks
    if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
        $error("rr_merge_arbiter: NUM_INPUTS must be in 2..16");
    end
    if ((1 << ID_WIDTH) < NUM_INPUTS) begin : g_bad_id_width
        $error("rr_merge_arbiter: ID_WIDTH too narrow for NUM_INPUTS");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("rr_merge_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        SEL  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        ptr_nxt;
    logic [NUM_INPUTS-1:0]   req_l_q, req_l_d;
    logic                    ack_r_q, ack_r_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [ID_WIDTH-1:0]     dout_id_q, dout_id_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT) + 1;
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
`endif

    // Unpack the flat upstream data bus into per-channel slices
    logic [DATA_WIDTH-1:0] din_arr [NUM_INPUTS];
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_slice
        assign din_arr[g] = din[DATA_WIDTH*g +: DATA_WIDTH];
    end

    // Wrapping successor: the channel just served drops to lowest priority
    always_comb begin
        ptr_nxt = '0;
        if (ptr_q != PTR_W'(NUM_INPUTS - 1)) begin
            ptr_nxt = ptr_q + PTR_W'(1);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_l_d   = req_l_q;
        ack_r_d   = ack_r_q;
        dout_d    = dout_q;
        dout_id_d = dout_id_q;
`ifdef ARB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif
        case (state_q)
            SEL: begin
                req_l_d = NUM_INPUTS'(1) << ptr_q;
`ifdef ARB_TIMEOUT_EN
                tcnt_d  = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                // An ack in the expiry cycle still wins over the skip
                if (ack_l[ptr_q]) begin
                    dout_d    = din_arr[ptr_q];
                    dout_id_d = ID_WIDTH'(ptr_q);
                    req_l_d   = '0;
                    state_d   = HOLD;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    req_l_d = '0;
                    ptr_d   = ptr_nxt;
                    state_d = SEL;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
`endif
            end
            HOLD: begin
                if (req_r) begin
                    ack_r_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ack_r_d = 1'b0;
                ptr_d   = ptr_nxt;
                state_d = SEL;
            end
            default: begin
                state_d = SEL;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEL;
            ptr_q     <= '0;
            req_l_q   <= '0;
            ack_r_q   <= 1'b0;
            dout_q    <= '0;
            dout_id_q <= '0;
`ifdef ARB_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            req_l_q   <= req_l_d;
            ack_r_q   <= ack_r_d;
            dout_q    <= dout_d;
            dout_id_q <= dout_id_d;
`ifdef ARB_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
`endif
        end
    end

    assign req_l   = req_l_q;
    assign ack_r   = ack_r_q;
    assign dout    = dout_q;
    assign dout_id = dout_id_q;

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// tb_rr_merge_arbiter: randomized bench for rr_merge_arbiter with a
// transaction-level reference model (expected channel order, token queue,
// handshake timing) and directed phases for backpressure, stalls, timeout
// and mid-operation reset.
`timescale 1ns/1ps
module tb_rr_merge_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;
    localparam int unsigned TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TOTAL = 1300;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_l;
    logic [N-1:0]   ack_l;
    logic [DW*N-1:0] din;
    logic           req_r;
    logic           ack_r;
    logic [DW-1:0]  dout;
    logic [IW-1:0]  dout_id;

    always #5 clk = ~clk;

    rr_merge_arbiter #(
        .NUM_INPUTS(N),
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW),
        .TIMEOUT   (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_l  (req_l),
        .ack_l  (ack_l),
        .din    (din),
        .req_r  (req_r),
        .ack_r  (ack_r),
        .dout   (dout),
        .dout_id(dout_id)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int unsigned   ch;
        logic [DW-1:0] val;
    } tok_t;

    function automatic logic [N-1:0] oh(input int unsigned c);
        logic [N-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic int unsigned nxt(input int unsigned c);
        return (c == N - 1) ? 0 : c + 1;
    endfunction

    // 0 full rate, 1 random, 2 backpressure, 3 channel-1 stall, 4 expiry race, 5 reset
    function automatic int mode_of(input int cyc);
        if (cyc < 40)   return 0;
        if (cyc < 440)  return 1;
        if (cyc < 600)  return 2;
        if (cyc < 800)  return 3;
        if (cyc < 900)  return 4;
        if (cyc < 1000) return 5;
        return 1;
    endfunction

    initial begin
        int unsigned   exp_ch;
        int            req_due, high_cnt, hold_cnt, last_ack, last_mode, mode;
        bit            d_rst, d_cap, d_skip, d_rr, d_hold, rst_done, exp_ack, hold, go;
        tok_t          d_tok;
        tok_t          q[$];
        logic [DW-1:0] nxt_val [N];
        logic [DW-1:0] data;

        rst   = 1'b1;
        req_r = 1'b0;
        ack_l = '0;
        din   = '0;
        d_rst = 1'b1; d_cap = 1'b0; d_skip = 1'b0; d_rr = 1'b0; d_hold = 1'b0;
        rst_done = 1'b0;
        exp_ch = 0; req_due = 0; high_cnt = 0; hold_cnt = 0;
        last_ack = -1; last_mode = 0;
        d_tok.ch = 0; d_tok.val = '0;
        for (int i = 0; i < N; i++) nxt_val[i] = '0;

        for (int cyc = 0; cyc < TOTAL; cyc++) begin
            @(posedge clk);
            #1;
            mode = mode_of(cyc);
            if (cyc == 440) nxt_val[2] = DW'(7);

            // ---- compare DUT against the model ----
            if (d_rst) begin
                check_eq("rst_req_l",   64'(req_l),   64'(0));
                check_eq("rst_ack_r",   64'(ack_r),   64'(0));
                check_eq("rst_dout",    64'(dout),    64'(0));
                check_eq("rst_dout_id", 64'(dout_id), 64'(0));
                q.delete();
                exp_ch = 0; req_due = 1; high_cnt = 0; hold_cnt = 0; last_ack = -1;
            end else begin
                exp_ack = d_hold && d_rr;
                check_eq("ack_r", 64'(ack_r), 64'(exp_ack));
                if (d_cap) q.push_back(d_tok);
                if (req_due > 0) begin
                    req_due--;
                    check_eq("req_l_timing", 64'(req_l),
                             (req_due == 0) ? 64'(oh(exp_ch)) : 64'(0));
                end
                if (exp_ack && q.size() != 0) begin
                    check_eq("ack_dout",    64'(dout),    64'(q[0].val));
                    check_eq("ack_dout_id", 64'(dout_id), 64'(q[0].ch));
                    if (last_ack >= 0) begin
                        if (mode == 0 && last_mode == 0)
                            check_eq("ack_period", 64'(cyc - last_ack), 64'(5));
                        else
                            check_eq("ack_spacing", 64'(cyc - last_ack >= 5), 64'(1));
                    end
                    last_ack  = cyc;
                    last_mode = mode;
                    void'(q.pop_front());
                    exp_ch  = nxt(exp_ch);
                    req_due = 2;
                end else if (q.size() != 0) begin
                    check_eq("hold_dout",    64'(dout),    64'(q[0].val));
                    check_eq("hold_dout_id", 64'(dout_id), 64'(q[0].ch));
                    check_eq("hold_req_l",   64'(req_l),   64'(0));
                end
                if (d_skip) begin
                    check_eq("skip_req_l", 64'(req_l), 64'(0));
                    exp_ch  = nxt(exp_ch);
                    req_due = 1;
                end
                if (req_l != '0) check_eq("req_l_sel", 64'(req_l), 64'(oh(exp_ch)));
            end

            // ---- drive inputs for the coming cycle ----
            d_rst = 1'b0; d_cap = 1'b0; d_skip = 1'b0;
            if (mode == 5 && !rst_done && q.size() != 0) begin
                rst      = 1'b1;
                req_r    = 1'b0;
                ack_l    = '0;
                d_rst    = 1'b1;
                rst_done = 1'b1;
                d_rr     = 1'b0;
                d_hold   = 1'b0;
            end else begin
                rst  = 1'b0;
                hold = (q.size() != 0);
                hold_cnt = hold ? hold_cnt + 1 : 0;
                case (mode)
                    0, 3, 4: req_r = 1'b1;
                    2:       req_r = (hold_cnt > 20);
                    default: req_r = ($urandom_range(9) < 6);
                endcase
                d_rr   = req_r;
                d_hold = hold;
                // Noise on every channel; only the selected, requested one may capture
                for (int i = 0; i < N; i++) begin
                    din[i*DW +: DW] = DW'($urandom);
                    ack_l[i]        = ($urandom_range(3) == 0);
                end
                if (req_l[exp_ch]) begin
                    high_cnt++;
                    data = nxt_val[exp_ch];
                    case (mode)
                        1, 5:    go = (high_cnt >= 2) && ($urandom_range(2) != 0);
                        3:       go = (exp_ch == 1) ? (!TO_EN && high_cnt >= 51) : (high_cnt >= 2);
                        4:       go = (exp_ch == 1) ? (high_cnt >= int'(TO)) : (high_cnt >= 2);
                        default: go = (high_cnt >= 2);
                    endcase
                    if (mode == 3 && exp_ch == 1) data = DW'(9);
                    if (mode == 4 && exp_ch == 1) data = DW'(32'h55);
                    ack_l[exp_ch] = go;
                    if (go) begin
                        din[exp_ch*DW +: DW] = data;
                        d_cap     = 1'b1;
                        d_tok.ch  = exp_ch;
                        d_tok.val = data;
                        nxt_val[exp_ch] = nxt_val[exp_ch] + DW'(1);
                    end else if (TO_EN && high_cnt == int'(TO)) begin
                        d_skip = 1'b1;
                    end
                end else begin
                    high_cnt = 0;
                end
            end
        end

        check_eq("mid_reset_seen", 64'(rst_done), 64'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_merge_arbiter.md
Name: rr_merge_arbiter

Overview:
- Round-robin merge node that shares one downstream consumer channel among NUM_INPUTS upstream producer channels.
- Uses the dataflow req/ack handshake of the operator graph: the block requests from upstream and acknowledges downstream.
- Each forwarded token carries the index of its source channel.
- Used wherever several graph edges converge on one consumer, for example a shared output port or a shared functional unit.

Parameters:
NUM_INPUTS, 4, number of upstream channels (2..16)
DATA_WIDTH, 32, token width in bits
ID_WIDTH, 2, width of the source id; must satisfy 2**ID_WIDTH >= NUM_INPUTS
TIMEOUT, 8, cycles to wait for an upstream ack before skipping that channel (>=1; only used with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_l  output  NUM_INPUTS  request to upstream channel i (one-hot or zero)
ack_l  input  NUM_INPUTS  upstream ack pulse; data is valid on din slice i in the same cycle
din  input  DATA_WIDTH*NUM_INPUTS  upstream data; channel i is bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
req_r  input  1  downstream request (level)
ack_r  output  1  downstream ack, one-cycle pulse
dout  output  DATA_WIDTH  forwarded token
dout_id  output  ID_WIDTH  source channel of dout

Behaviour:
- Reset is synchronous and active-high on clk rst. It forces:
  - req_l=0, ack_r=0, dout=0, dout_id=0
  - pointer ptr=0, timeout counter tcnt=0, state=SEL
- Reset mid-transfer drops any held token; the upstream channel is re-requested after reset.
- FSM states: SEL, WAIT, HOLD, DONE.
- SEL:
  - req_l <= one-hot(ptr); tcnt <= 0; go to WAIT.
- WAIT:
  - If ack_l[ptr]=1: dout <= din slice ptr; dout_id <= ptr; req_l <= 0; go to HOLD.
  - Else, with ARB_TIMEOUT_EN, if tcnt == TIMEOUT-1: req_l <= 0; ptr <= next(ptr); go to SEL.
  - Otherwise tcnt <= tcnt+1.
- HOLD:
  - If req_r=1: ack_r <= 1; go to DONE.
  - Otherwise wait indefinitely with dout stable.
- DONE:
  - ack_r <= 0; ptr <= next(ptr); go to SEL.
- next(p) = (p == NUM_INPUTS-1) ? 0 : p+1. This wraps round-robin; after a grant the served channel becomes lowest priority.
- Handshake rules:
  - At most one req_l bit is ever high.
  - ack_l bits for non-selected channels are ignored and do not capture data.
  - An ack_l[ptr] that arrives in the same cycle the timeout expires wins: the data is captured and no skip occurs.
- dout and dout_id change only on capture and are stable while ack_r=1.
- ack_r is exactly one cycle wide, and the next ack_r pulse is at least 4 cycles later.
- Latency, with an upstream that acks in the cycle after it sees req and req_r already high:
  - req_l rises 1 cycle after SEL
  - capture at cycle 3
  - ack_r high at cycle 4
  - peak rate is one token per 5 cycles
- Downstream backpressure (req_r=0) stalls only in HOLD; no upstream request is outstanding during the stall.
- Width rules:
  - tcnt width is clog2(TIMEOUT)+1.
  - dout_id is ptr zero-extended to ID_WIDTH.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: the WAIT timeout skip is compiled in, so an idle channel costs at most TIMEOUT+1 cycles before the next channel is requested.
- Undefined:
  - The tcnt logic is absent and the TIMEOUT parameter is unused.
  - WAIT holds req_l on the selected channel until it acks.
  - Strict round-robin order is preserved even if a channel stalls forever.

Test Plan:
- Reset check: NUM_INPUTS=4, all producers always ready, consumer always requests -> dout_id sequence 0,1,2,3,0,…; ack_r pulses every 5 cycles; each channel's value stream increments 0,1,2… independently.
- Backpressure: hold req_r=0 for 20 cycles while in HOLD with token 7 from channel 2 -> ack_r stays 0, req_l=0, dout=7; req_r rises -> ack_r pulses next cycle with dout=7, dout_id=2.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): channel 1 never acks -> req_l[1] high for exactly 8 cycles, then req_l[2] rises; dout_id never equals 1; channels 0, 2, 3 served in order.
- Timeout/ack race: channel 1 acks with value 0x55 exactly in the cycle tcnt=TIMEOUT-1 -> token captured, dout=0x55, dout_id=1, no skip.
- No timeout (macro undefined): channel 1 stalls 50 cycles, then acks value 9 -> no other channel is requested during the stall; the next token is dout=9, dout_id=1.
- Reset mid-operation: assert rst for 1 cycle while in HOLD -> next cycle req_l=0, ack_r=0, dout=0, dout_id=0; first post-reset request goes to channel 0.
